// File: rtl/ifetch_mem_responder_if.sv
// Instruction-fetch memory bus between the IFU (master) and the memory responder (slave).
//
// Signals
//   req_valid  / req_ready   fetch request handshake, req_addr is the byte address
//   resp_valid / resp_ready  response handshake, resp_data is the fetched word,
//                            resp_err flags an access fault
//   wr_en / wr_addr / wr_data  loader write port into the instruction store
//
// Modports
//   master  IFU / loader side
//   slave   responder side
interface ifetch_mem_responder_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output req_valid, req_addr, resp_ready, wr_en, wr_addr, wr_data,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, wr_en, wr_addr, wr_data,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/ifetch_mem_responder.sv
// Memory-side responder for instruction fetch. Accepts one request at a time, reads a word from
// an internal word-addressed array and returns it LAT cycles after the accepting edge over a
// valid/ready handshake. A write port lets a loader fill the array in any state.
//
// Ports
//   clk   clock, all state on the rising edge
//   rst   synchronous, active-low reset (array contents are not reset)
//   bus   ifetch_mem_responder_if.slave: request, response and write channels
//
// Word index = ((addr - BASE_ADDR) >> 2) truncated to log2(DEPTH) bits.
//
// Optional feature, macro IFETCH_RESP_ALIGN_CHECK_EN:
//   defined   misaligned or out-of-window fetches respond with resp_err=1, resp_data=0 after the
//             normal latency; out-of-window writes are dropped.
//   undefined addr[1:0] ignored, index wraps modulo DEPTH, resp_err always 0.
module ifetch_mem_responder #(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000),
    parameter int unsigned       LAT       = 2
) (
    input logic                  clk,
    input logic                  rst,
    ifetch_mem_responder_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

`ifdef IFETCH_RESP_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH) << 2;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
    endfunction

    function automatic logic fault(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || !in_range(a);
    endfunction
`endif

    // Array write port: active in every state, including reset. Uses NBA so a read on the same
    // edge sees the old word.
    always_ff @(posedge clk) begin
`ifdef IFETCH_RESP_ALIGN_CHECK_EN
        if (bus.wr_en && in_range(bus.wr_addr)) begin
            mem[word_idx(bus.wr_addr)] <= bus.wr_data;
        end
`else
        if (bus.wr_en) begin
            mem[word_idx(bus.wr_addr)] <= bus.wr_data;
        end
`endif
    end

    // Accept at edge N loads cnt=LAT-1; WAIT counts down to zero and moves to RESP on the next
    // edge, so resp_valid rises after edge N+LAT for every LAT >= 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid && bus.req_ready) begin
                        addr_q        <= bus.req_addr;
                        cnt_q         <= CNT_W'(LAT - 1);
                        bus.req_ready <= 1'b0;
                        state_q       <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q        <= StResp;
                        bus.resp_valid <= 1'b1;
`ifdef IFETCH_RESP_ALIGN_CHECK_EN
                        if (fault(addr_q)) begin
                            bus.resp_data <= '0;
                            bus.resp_err  <= 1'b1;
                        end else begin
                            bus.resp_data <= mem[word_idx(addr_q)];
                            bus.resp_err  <= 1'b0;
                        end
`else
                        bus.resp_data <= mem[word_idx(addr_q)];
                        bus.resp_err  <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    // resp_data/resp_err are held until the handshake completes.
                    if (bus.resp_ready) begin
                        state_q        <= StIdle;
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q        <= StIdle;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_mem_responder.sv
// Directed bench for ifetch_mem_responder with default parameters (LAT=2, DEPTH=1024,
// BASE_ADDR=0x8000_0000). Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_ifetch_mem_responder;
    logic clk;
    logic rst;

    ifetch_mem_responder_if #(.ADDR_W(64), .DATA_W(32)) bus ();

    ifetch_mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [63:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    // Issue one fetch with resp_ready held high; waits are bounded.
    task automatic fetch(input logic [63:0] a, output logic [31:0] d, output logic e);
        int n;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        tick();
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            tick();
            n++;
        end
        check("fetch_resp_seen", {63'd0, bus.resp_valid}, 64'd1);
        d = bus.resp_data;
        e = bus.resp_err;
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    logic [31:0] d;
    logic        e;
    int          seen;

    initial begin
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;

        // Reset state
        tick();
        tick();
        check("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        check("rst_resp_data", {32'd0, bus.resp_data}, 64'd0);
        check("rst_resp_err", {63'd0, bus.resp_err}, 64'd0);
        rst = 1'b1;

        write_word(64'h8000_0000, 32'hDEAD_BEEF);
        write_word(64'h8000_0004, 32'h0010_0093);
        write_word(64'h8000_0008, 32'h1111_1111);

        // Basic fetch with exact latency: accept at edge N, valid after edge N+2
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'h8000_0004;
        tick();                          // edge N
        bus.req_valid = 1'b0;
        check("lat_ready_low", {63'd0, bus.req_ready}, 64'd0);
        check("lat_n0_valid", {63'd0, bus.resp_valid}, 64'd0);
        tick();                          // edge N+1
        check("lat_n1_valid", {63'd0, bus.resp_valid}, 64'd0);
        tick();                          // edge N+2
        check("lat_n2_valid", {63'd0, bus.resp_valid}, 64'd1);
        check("lat_data", {32'd0, bus.resp_data}, 64'h0010_0093);
        check("lat_err", {63'd0, bus.resp_err}, 64'd0);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("hs_valid_low", {63'd0, bus.resp_valid}, 64'd0);
        check("hs_ready_high", {63'd0, bus.req_ready}, 64'd1);

        // Backpressure: three stalled cycles in RESP with a competing request that must be ignored
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'h8000_0000;
        tick();
        bus.req_addr = 64'h8000_0004;    // stays valid, must not be accepted
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", {63'd0, bus.resp_valid}, 64'd1);
            check("bp_data", {32'd0, bus.resp_data}, 64'hDEAD_BEEF);
            check("bp_req_ready", {63'd0, bus.req_ready}, 64'd0);
            tick();
        end
        bus.req_valid  = 1'b0;
        check("bp_data_last", {32'd0, bus.resp_data}, 64'hDEAD_BEEF);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("bp_idle_valid", {63'd0, bus.resp_valid}, 64'd0);
        check("bp_idle_ready", {63'd0, bus.req_ready}, 64'd1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.resp_valid) seen++;
        end
        check("bp_not_queued", 64'(seen), 64'd0);

        // Write to the held word while in RESP must not alter resp_data
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'h8000_0004;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        write_word(64'h8000_0004, 32'h3333_3333);
        check("hold_valid", {63'd0, bus.resp_valid}, 64'd1);
        check("hold_data", {32'd0, bus.resp_data}, 64'h0010_0093);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        fetch(64'h8000_0004, d, e);
        check("hold_new_word", {32'd0, d}, 64'h3333_3333);

        // Misaligned and out-of-window addresses
        fetch(64'h8000_0002, d, e);
`ifdef IFETCH_RESP_ALIGN_CHECK_EN
        check("misalign_err", {63'd0, e}, 64'd1);
        check("misalign_data", {32'd0, d}, 64'd0);
        fetch(64'h7FFF_FFFC, d, e);
        check("below_err", {63'd0, e}, 64'd1);
        check("below_data", {32'd0, d}, 64'd0);
        fetch(64'h8000_1000, d, e);
        check("above_err", {63'd0, e}, 64'd1);
        write_word(64'h8000_1000, 32'h5555_5555);   // dropped: must not alias onto word 0
        fetch(64'h8000_0000, d, e);
        check("oor_write_dropped", {32'd0, d}, 64'hDEAD_BEEF);
`else
        check("misalign_err", {63'd0, e}, 64'd0);
        check("misalign_data", {32'd0, d}, 64'hDEAD_BEEF);
        fetch(64'h8000_1004, d, e);                 // wraps to word 1
        check("wrap_data", {32'd0, d}, 64'h3333_3333);
        check("wrap_err", {63'd0, e}, 64'd0);
        write_word(64'h8000_1000, 32'h5555_5555);   // wraps onto word 0
        fetch(64'h8000_0000, d, e);
        check("wrap_write", {32'd0, d}, 64'h5555_5555);
`endif

        // Reset during WAIT drops the request
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'h8000_0008;
        bus.resp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rstwait_ready", {63'd0, bus.req_ready}, 64'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.resp_valid) seen++;
            tick();
        end
        check("rstwait_no_resp", 64'(seen), 64'd0);
        bus.resp_ready = 1'b0;

        // Same-word write on the read edge returns the old word
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'h8000_0008;
        tick();                          // edge N
        bus.req_valid = 1'b0;
        tick();                          // edge N+1
        write_word(64'h8000_0008, 32'h2222_2222);   // lands on edge N+2, the read edge
        check("coll_valid", {63'd0, bus.resp_valid}, 64'd1);
        check("coll_old", {32'd0, bus.resp_data}, 64'h1111_1111);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        fetch(64'h8000_0008, d, e);
        check("coll_new", {32'd0, d}, 64'h2222_2222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
